// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial burst slave: start pattern, FSM states
// and frame field positions as functions of the ID and address widths.
package serial_bus_pkg;

    localparam logic [2:0] START_PATTERN = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        DECODE,
        RFETCH,
        READ,
        WRITE,
        WCOMMIT
    } state_t;

    // Field positions inside the captured frame register. Bit 0 of the frame
    // (first on the wire) ends up in the MSB after FRAME_LEN shifts.
    function automatic int frame_len(input int slaveid_w, input int addr_w);
        return 3 + slaveid_w + 2 + addr_w;
    endfunction

    function automatic int burst_pos(input int addr_w);
        return addr_w;
    endfunction

    function automatic int rw_pos(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int id_lsb(input int addr_w);
        return addr_w + 2;
    endfunction

    function automatic int start_lsb(input int slaveid_w, input int addr_w);
        return addr_w + 2 + slaveid_w;
    endfunction

endpackage

// File: rtl/slave_ram.sv
// Single-port synchronous RAM with a registered read port (1-cycle latency).
module slave_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_DEPTH = 2048,
    parameter int ADDR_W     = $clog2(ADDR_DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; contents survive a reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/serial_burst_slave.sv
// Serial bus slave: decodes a serial control frame, then streams single or
// burst reads/writes of the local RAM one data bit per cycle.
module serial_burst_slave
    import serial_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_DEPTH = 2048,
    parameter int SLAVES     = 3,
    parameter int SLAVEID_W  = $clog2(SLAVES),
    parameter int ADDR_W     = $clog2(ADDR_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SLAVEID_W-1:0] slave_ID,
    input  logic                 control,
    input  logic                 wD,
    input  logic                 valid,
    input  logic                 last,
    output logic                 rD,
    output logic                 ready,
    output logic                 err
);

    localparam int FRAME_LEN = frame_len(SLAVEID_W, ADDR_W);
    localparam int CNT_MAX   = (FRAME_LEN > DATA_WIDTH) ? FRAME_LEN : DATA_WIDTH;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  FRAME_END  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  WORD_END   = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_TOP   = ADDR_W'(ADDR_DEPTH - 1);
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(ADDR_DEPTH);

    state_t                state, state_d;
    logic [FRAME_LEN-1:0]  frame_q, frame_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic                  burst_q, burst_d;
    logic                  last_q, last_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wbuf, wbuf_d;
    logic [DATA_WIDTH-1:0] rbuf, rbuf_d;

    logic [2:0]            f_start;
    logic [SLAVEID_W-1:0]  f_id;
    logic                  f_rw, f_burst;
    logic [ADDR_W-1:0]     f_addr;
    logic                  start_bad, id_bad, addr_bad;
    logic                  word_done;
    logic [ADDR_W-1:0]     next_addr;

    logic                  ram_en, ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign f_start   = frame_q[start_lsb(SLAVEID_W, ADDR_W) +: 3];
    assign f_id      = frame_q[id_lsb(ADDR_W) +: SLAVEID_W];
    assign f_rw      = frame_q[rw_pos(ADDR_W)];
    assign f_burst   = frame_q[burst_pos(ADDR_W)];
    assign f_addr    = frame_q[ADDR_W-1:0];

    assign start_bad = (f_start != START_PATTERN);
    assign id_bad    = (f_id != slave_ID);
    assign addr_bad  = ({1'b0, f_addr} >= ADDR_LIMIT);
    assign word_done = (cnt == WORD_END);
    assign next_addr = (addr_q == ADDR_TOP) ? '0 : addr_q + 1'b1;

    // The RAM read is issued one cycle ahead of RFETCH (in DECODE or on the
    // final bit of the previous word) so RFETCH can load the shift buffer.
    assign ram_en   = ((state == DECODE) && !addr_bad) ||
                      ((state == READ) && word_done) ||
                      (state == WCOMMIT);
    assign ram_we   = (state == WCOMMIT);
    assign ram_addr = (state == DECODE) ? f_addr :
                      (state == READ)   ? next_addr : addr_q;

    assign rD = (state == READ) ? rbuf[DATA_WIDTH-1] : 1'b0;

    slave_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_DEPTH (ADDR_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wbuf),
        .rdata (ram_rdata)
    );

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state;
        frame_d = frame_q;
        cnt_d   = cnt;
        burst_d = burst_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf;
        rbuf_d  = rbuf;
        ready   = 1'b1;
        err     = 1'b0;

        case (state)
            IDLE: begin
                if (control) begin
                    frame_d = {frame_q[FRAME_LEN-2:0], 1'b1};
                    cnt_d   = CNT_W'(1);
                    state_d = CFG;
                end
            end
            CFG: begin
                frame_d = {frame_q[FRAME_LEN-2:0], control};
                cnt_d   = cnt + 1'b1;
                if (cnt == FRAME_END) begin
                    cnt_d   = '0;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // Priority: bad start, then foreign ID (silent), then range.
                state_d = IDLE;
                if (start_bad) begin
                    err = 1'b1;
                end else if (!id_bad) begin
                    if (addr_bad) begin
                        err = 1'b1;
                    end else begin
                        burst_d = f_burst;
                        addr_d  = f_addr;
                        state_d = f_rw ? WRITE : RFETCH;
                    end
                end
            end
            RFETCH: begin
                ready   = 1'b0;
                rbuf_d  = ram_rdata;
                cnt_d   = '0;
                state_d = READ;
            end
            READ: begin
                rbuf_d = {rbuf[DATA_WIDTH-2:0], 1'b0};
                cnt_d  = cnt + 1'b1;
                if (word_done) begin
                    cnt_d = '0;
                    if (burst_q && !last) begin
                        addr_d  = next_addr;
                        state_d = RFETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                if (valid) begin
                    wbuf_d = {wbuf[DATA_WIDTH-2:0], wD};
                    cnt_d  = cnt + 1'b1;
                    if (word_done) begin
                        cnt_d   = '0;
                        last_d  = last;
                        state_d = WCOMMIT;
                    end
                end
            end
            WCOMMIT: begin
                ready = 1'b0;
                if (burst_q && !last_q) begin
                    addr_d  = next_addr;
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            frame_q <= '0;
            cnt     <= '0;
            burst_q <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            wbuf    <= '0;
            rbuf    <= '0;
        end else begin
            state   <= state_d;
            frame_q <= frame_d;
            cnt     <= cnt_d;
            burst_q <= burst_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wbuf    <= wbuf_d;
            rbuf    <= rbuf_d;
        end
    end

endmodule

// File: tb/tb_serial_burst_slave.sv
// Directed bench: transaction tasks schedule per-cycle expectations from a
// word-level memory model; one negedge process compares the DUT against them.
module tb_serial_burst_slave;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int NSL   = 3;
    localparam int FL    = 11;
    localparam logic [1:0] SID = 2'd2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic control = 1'b0, wD = 1'b0, valid = 1'b0, last = 1'b0;
    logic a_rD, a_ready, a_err;
    logic b_rD, b_ready, b_err;

    // Main instance, plus a 12-word instance on the same wires whose only
    // job is to flag an in-field but out-of-range address.
    serial_burst_slave #(.DATA_WIDTH(DW), .ADDR_DEPTH(DEPTH), .SLAVES(NSL)) dut_a (
        .clk(clk), .reset(reset), .slave_ID(SID), .control(control), .wD(wD),
        .valid(valid), .last(last), .rD(a_rD), .ready(a_ready), .err(a_err)
    );

    serial_burst_slave #(.DATA_WIDTH(DW), .ADDR_DEPTH(12), .SLAVES(NSL)) dut_b (
        .clk(clk), .reset(reset), .slave_ID(SID), .control(control), .wD(wD),
        .valid(valid), .last(last), .rD(b_rD), .ready(b_ready), .err(b_err)
    );

    always #5 clk = ~clk;

    logic exp_rD = 1'b0, exp_ready = 1'b1, exp_err = 1'b0, exp_b_err = 1'b0;
    logic chk_en = 1'b0, b_chk = 1'b0;
    logic cap_rd, cap_rdy;
    logic [7:0] mem [DEPTH];
    logic [7:0] tx [$];
    logic [7:0] rx [$];
    int n_cmp = 0;
    int n_bad = 0;
    int fl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_rD", a_rD, exp_rD);
            check("cyc_ready", a_ready, exp_ready);
            check("cyc_err", a_err, exp_err);
            if (b_chk) begin
                check("b_err", b_err, exp_b_err);
                check("b_ready", b_ready, 1);
                check("b_rD", b_rD, 0);
            end
        end
    end

    // One bus cycle: drive inputs, publish expectations, capture outputs.
    task automatic cyc(input logic c, input logic w, input logic v, input logic l,
                       input logic e_rd, input logic e_rdy, input logic e_err);
        control = c; wD = w; valid = v; last = l;
        exp_rD = e_rd; exp_ready = e_rdy; exp_err = e_err;
        @(negedge clk);
        cap_rd  = a_rD;
        cap_rdy = a_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    function automatic logic [3:0] adv(input logic [3:0] a);
        return (a == 4'(DEPTH - 1)) ? 4'd0 : a + 4'd1;
    endfunction

    // Frame bits followed by the decode cycle.
    task automatic send_frame(input logic [2:0] st, input logic [1:0] id, input logic rw,
                              input logic burst, input logic [3:0] ad, input logic b_err_exp);
        logic [FL-1:0] fr;
        logic e;
        fr = {st, id, rw, burst, ad};
        for (int i = FL - 1; i >= 0; i--) cyc(fr[i], 1'(i), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        e = (st != 3'b111) || ((id == SID) && ({1'b0, ad} >= 5'(DEPTH)));
        exp_b_err = b_err_exp;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, e);
        exp_b_err = 1'b0;
    endtask

    // Writes the words in tx; first_low is the DUT-observed cycle offset
    // (from the first data cycle) at which ready first drops.
    task automatic do_write(input logic [3:0] ad, input logic burst, input int stall_after,
                            input int stall_len, input logic b_err_exp, output int first_low);
        logic [3:0] a;
        logic [7:0] w;
        logic lst;
        int k, j, sc;
        send_frame(3'b111, SID, 1'b1, burst, ad, b_err_exp);
        a = ad;
        first_low = -1;
        foreach (tx[wi]) begin
            w = tx[wi]; j = 0; k = 0; sc = 0;
            while (j < DW) begin
                if (j == stall_after && sc < stall_len) begin
                    cyc(1'b0, ~w[DW-1-j], 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
                    sc++;
                end else begin
                    lst = burst && (wi == tx.size() - 1) && (j == DW - 1);
                    cyc(1'b0, w[DW-1-j], 1'b1, lst, 1'b0, 1'b1, 1'b0);
                    j++;
                end
                if (!cap_rdy && first_low < 0) first_low = k;
                k++;
            end
            cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            if (!cap_rdy && first_low < 0) first_low = k;
            mem[a] = w;
            a = adv(a);
        end
    endtask

    task automatic do_read(input logic [3:0] ad, input logic burst, input int n);
        logic [3:0] a;
        logic [7:0] r;
        logic lst;
        send_frame(3'b111, SID, 1'b0, burst, ad, 1'b0);
        a = ad;
        rx.delete();
        for (int wi = 0; wi < n; wi++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            r = '0;
            for (int j = 0; j < DW; j++) begin
                lst = burst && (wi == n - 1) && (j == DW - 1);
                cyc(1'b0, 1'(j), 1'b1, lst, mem[a][DW-1-j], 1'b1, 1'b0);
                r = {r[DW-2:0], cap_rd};
            end
            rx.push_back(r);
            a = adv(a);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rD", a_rD, 0);
        check("reset_ready", a_ready, 1);
        check("reset_err", a_err, 0);
        reset = 1'b0;
        idle(2);

        // Single write then read of 8'hA5 at address 3.
        tx = '{8'hA5};
        do_write(4'd3, 1'b0, -1, 0, 1'b0, fl);
        check("commit_offset_plain", fl, 8);
        idle(2);
        do_read(4'd3, 1'b0, 1);
        check("read_a5", rx[0], 8'hA5);
        idle(2);

        // Burst write wrapping 14 -> 15 -> 0, then burst read back.
        tx = '{8'h11, 8'h22, 8'h33};
        do_write(4'd14, 1'b1, -1, 0, 1'b0, fl);
        idle(1);
        do_read(4'd14, 1'b1, 3);
        check("burst_w0", rx[0], 8'h11);
        check("burst_w1", rx[1], 8'h22);
        check("burst_w2", rx[2], 8'h33);
        idle(1);
        do_read(4'd0, 1'b0, 1);
        check("wrap_addr0", rx[0], 8'h33);
        idle(2);

        // Write with three valid-low cycles after four bits.
        tx = '{8'hC3};
        do_write(4'd5, 1'b0, 4, 3, 1'b0, fl);
        check("commit_offset_stall", fl, 11);
        idle(1);
        do_read(4'd5, 1'b0, 1);
        check("read_c3", rx[0], 8'hC3);
        idle(2);

        // Bad start pattern, then a foreign ID; both followed by junk data.
        send_frame(3'b110, SID, 1'b1, 1'b0, 4'd3, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(3'b111, 2'd1, 1'b1, 1'b0, 4'd3, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        do_read(4'd3, 1'b0, 1);
        check("read_after_bad", rx[0], 8'hA5);
        idle(2);

        // Address 13: valid for the 16-word slave, out of range for the 12-word one.
        b_chk = 1'b1;
        tx = '{8'h9C};
        do_write(4'd13, 1'b0, -1, 0, 1'b1, fl);
        idle(2);
        b_chk = 1'b0;
        do_read(4'd13, 1'b0, 1);
        check("read_9c", rx[0], 8'h9C);
        idle(2);

        // Reset during the second word of a write burst.
        tx = '{8'hE7};
        do_write(4'd9, 1'b0, -1, 0, 1'b0, fl);
        idle(1);
        send_frame(3'b111, SID, 1'b1, 1'b1, 4'd8, 1'b0);
        w = 8'h5A;
        for (int j = 0; j < DW; j++) cyc(1'b0, w[DW-1-j], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mem[8] = 8'h5A;
        w = 8'h96;
        for (int j = 0; j < 4; j++) cyc(1'b0, w[DW-1-j], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        control = 1'b0; valid = 1'b0; wD = 1'b0; last = 1'b0;
        exp_rD = 1'b0; exp_ready = 1'b1; exp_err = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_rD", a_rD, 0);
        check("midrst_ready", a_ready, 1);
        check("midrst_err", a_err, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
        do_read(4'd8, 1'b1, 2);
        check("kept_word1", rx[0], 8'h5A);
        check("kept_next", rx[1], 8'hE7);
        idle(2);

        // Reset while ready is low (read fetch) must raise ready at once.
        send_frame(3'b111, SID, 1'b0, 1'b0, 4'd8, 1'b0);
        exp_rD = 1'b0; exp_ready = 1'b1; exp_err = 1'b0;
        reset = 1'b1;
        #1;
        check("fetch_rst_ready", a_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
